// File: rtl/alu_share_arb_if.sv
// Handshake and ALU bus between the two requesters, the arbiter and the ALU.
// slave: arbiter side; master: requesters plus ALU side.
interface alu_share_arb_if #(
  parameter int W   = 32,
  parameter int OPW = 4
);
  logic           req_valid0;
  logic           req_valid1;
  logic           req_ready0;
  logic           req_ready1;
  logic [W-1:0]   req_a0;
  logic [W-1:0]   req_b0;
  logic [W-1:0]   req_a1;
  logic [W-1:0]   req_b1;
  logic [OPW-1:0] req_op0;
  logic [OPW-1:0] req_op1;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_out;
  logic           alu_zero;
  logic           alu_overflow;
  logic           alu_sign;
  logic           rsp_valid0;
  logic           rsp_valid1;
  logic           rsp_ready0;
  logic           rsp_ready1;
  logic [W-1:0]   rsp_out;
  logic           rsp_zero;
  logic           rsp_overflow;
  logic           rsp_sign;
  logic           busy;

  modport slave (
    input  req_valid0, req_valid1,
    output req_ready0, req_ready1,
    input  req_a0, req_b0, req_a1, req_b1,
    input  req_op0, req_op1,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_zero, alu_overflow, alu_sign,
    output rsp_valid0, rsp_valid1,
    input  rsp_ready0, rsp_ready1,
    output rsp_out, rsp_zero, rsp_overflow, rsp_sign,
    output busy
  );

  modport master (
    output req_valid0, req_valid1,
    input  req_ready0, req_ready1,
    output req_a0, req_b0, req_a1, req_b1,
    output req_op0, req_op1,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_zero, alu_overflow, alu_sign,
    input  rsp_valid0, rsp_valid1,
    output rsp_ready0, rsp_ready1,
    input  rsp_out, rsp_zero, rsp_overflow, rsp_sign,
    input  busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_share_arb #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arb_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_out_q, rsp_out_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_sign_q, rsp_sign_d;

  logic gnt0, gnt1;
  logic rdy0, rdy1;
  logic own_ready;

  always_comb begin
    // On contention the port that did not win last time goes first.
    gnt1 = bus.req_valid1 & (~bus.req_valid0 | ~last_grant_q);
    gnt0 = bus.req_valid0 & ~gnt1;
    rdy0 = (state_q == IDLE) & gnt0 & ~rst;
    rdy1 = (state_q == IDLE) & gnt1 & ~rst;
    own_ready = owner_q ? bus.rsp_ready1 : bus.rsp_ready0;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_sign_d   = rsp_sign_q;

    unique case (state_q)
      IDLE: begin
        if (rdy0) begin
          alu_a_d      = bus.req_a0;
          alu_b_d      = bus.req_b0;
          alu_op_d     = bus.req_op0;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (rdy1) begin
          alu_a_d      = bus.req_a1;
          alu_b_d      = bus.req_b1;
          alu_op_d     = bus.req_op1;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = bus.alu_out;
        rsp_zero_d  = bus.alu_zero;
        rsp_ovf_d   = bus.alu_overflow;
        rsp_sign_d  = bus.alu_sign;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (own_ready) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_sign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_sign_q   <= rsp_sign_d;
    end
  end

  assign bus.req_ready0   = rdy0;
  assign bus.req_ready1   = rdy1;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.rsp_valid0   = rsp_valid_q[0];
  assign bus.rsp_valid1   = rsp_valid_q[1];
  assign bus.rsp_out      = rsp_out_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_sign     = rsp_sign_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU beside it.
// Inputs change 1ns after the falling edge; outputs are checked there.
module tb_alu_share_arb;
  localparam int W   = 32;
  localparam int OPW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_share_arb_if #(.W(W), .OPW(OPW)) bus ();

  alu_share_arb #(.W(W), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU model: sign reports a non-negative result, ADDu/SUBu overflow is carry/borrow.
  logic [W:0] ext;
  always_comb begin
    ext = '0;
    bus.alu_out = '0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_op)
      4'd0: begin
        bus.alu_out = bus.alu_a + bus.alu_b;
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) &&
                           (bus.alu_out[31] != bus.alu_a[31]);
      end
      4'd1: begin
        ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_out = ext[W-1:0];
        bus.alu_overflow = ext[W];
      end
      4'd2: begin
        bus.alu_out = bus.alu_a - bus.alu_b;
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) &&
                           (bus.alu_out[31] != bus.alu_a[31]);
      end
      4'd3: begin
        bus.alu_out = bus.alu_a - bus.alu_b;
        bus.alu_overflow = (bus.alu_a < bus.alu_b);
      end
      4'd4: bus.alu_out = bus.alu_a & bus.alu_b;
      4'd5: bus.alu_out = bus.alu_a | bus.alu_b;
      4'd6: bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'd7: bus.alu_out = ~(bus.alu_a | bus.alu_b);
      4'd8: bus.alu_out = ($signed(bus.alu_a) > 0) ? 32'd1 : 32'd0;
      default: bus.alu_out = '0;
    endcase
    bus.alu_zero = (bus.alu_out == '0);
    bus.alu_sign = ~bus.alu_out[31];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid0 = 0; bus.req_valid1 = 0;
    bus.rsp_ready0 = 0; bus.rsp_ready1 = 0;
  endtask

  task automatic set_req(input bit p, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (p) begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_valid1 = 1;
    end else begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_valid0 = 1;
    end
  endtask

  // One full transaction on port p starting from IDLE.
  task automatic run_op(input string tag, input bit p,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] eo,
                        input logic ez, input logic eov, input logic es);
    set_req(p, a, b, op);
    #1;
    chk({tag, ".ready"}, p ? bus.req_ready1 : bus.req_ready0, 1);
    chk({tag, ".ready_other"}, p ? bus.req_ready0 : bus.req_ready1, 0);
    tick();
    bus.req_valid0 = 0; bus.req_valid1 = 0;
    chk({tag, ".exec_busy"}, bus.busy, 1);
    chk({tag, ".alu_a"}, bus.alu_a, a);
    chk({tag, ".alu_op"}, {28'd0, bus.alu_op}, {28'd0, op});
    tick();
    chk({tag, ".rsp_valid"}, p ? bus.rsp_valid1 : bus.rsp_valid0, 1);
    chk({tag, ".rsp_valid_other"}, p ? bus.rsp_valid0 : bus.rsp_valid1, 0);
    chk({tag, ".rsp_out"}, bus.rsp_out, eo);
    chk({tag, ".flags"},
        {29'd0, bus.rsp_zero, bus.rsp_overflow, bus.rsp_sign},
        {29'd0, ez, eov, es});
    if (p) bus.rsp_ready1 = 1; else bus.rsp_ready0 = 1;
    tick();
    chk({tag, ".done_valid"}, {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 0);
    chk({tag, ".done_busy"}, bus.busy, 0);
    bus.rsp_ready0 = 0; bus.rsp_ready1 = 0;
  endtask

  initial begin
    idle_inputs();
    bus.req_a0 = 0; bus.req_b0 = 0; bus.req_op0 = 0;
    bus.req_a1 = 0; bus.req_b1 = 0; bus.req_op1 = 0;
    bus.req_valid0 = 1;
    tick();
    tick();
    chk("rst.ready0", bus.req_ready0, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.rsp_valid", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 0);
    chk("rst.rsp_out", bus.rsp_out, 0);
    chk("rst.alu_a", bus.alu_a, 0);
    bus.req_valid0 = 0;
    rst = 0;
    tick();

    run_op("single", 0, 32'd5, 32'd7, 4'd0, 32'd12, 0, 0, 1);
    run_op("ovf_add", 1, 32'h7FFF_FFFF, 32'd1, 4'd0,
           32'h8000_0000, 0, 1, 0);
    run_op("ovf_addu", 1, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd0, 1, 1, 1);
    run_op("illegal", 1, 32'd3, 32'd4, 4'hC, 32'd0, 1, 0, 1);
    run_op("bgtz", 0, 32'd9, 32'd0, 4'd8, 32'd1, 0, 0, 1);

    // Contention from reset: grants alternate starting with port 0.
    rst = 1;
    tick();
    rst = 0;
    set_req(0, 32'd9, 32'd9, 4'd2);
    set_req(1, 32'hF0, 32'h0F, 4'd5);
    bus.rsp_ready0 = 1; bus.rsp_ready1 = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d.ready0", k), bus.req_ready0, (k % 2) == 0);
      chk($sformatf("rr%0d.ready1", k), bus.req_ready1, (k % 2) == 1);
      tick();
      tick();
      chk($sformatf("rr%0d.rsp_valid0", k), bus.rsp_valid0, (k % 2) == 0);
      chk($sformatf("rr%0d.rsp_out", k), bus.rsp_out,
          (k % 2) ? 32'hFF : 32'h0);
      chk($sformatf("rr%0d.zero", k), bus.rsp_zero, (k % 2) == 0);
      tick();
    end
    idle_inputs();

    // Backpressure on port 0 while port 1 waits and asserts its own ready.
    rst = 1;
    tick();
    rst = 0;
    set_req(0, 32'd5, 32'd7, 4'd0);
    set_req(1, 32'hF0, 32'h0F, 4'd5);
    bus.rsp_ready1 = 1;
    tick();
    tick();
    chk("bp.rsp_valid0_rise", bus.rsp_valid0, 1);
    bus.req_valid0 = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.rsp_valid0", k), bus.rsp_valid0, 1);
      chk($sformatf("bp%0d.rsp_out", k), bus.rsp_out, 32'd12);
      chk($sformatf("bp%0d.busy", k), bus.busy, 1);
      chk($sformatf("bp%0d.ready1", k), bus.req_ready1, 0);
      tick();
    end
    bus.rsp_ready0 = 1;
    tick();
    chk("bp.release_valid0", bus.rsp_valid0, 0);
    chk("bp.release_busy", bus.busy, 0);
    chk("bp.ready1_next", bus.req_ready1, 1);
    bus.rsp_ready0 = 0;
    tick();
    bus.req_valid1 = 0;
    chk("bp.p1_alu_a", bus.alu_a, 32'hF0);
    tick();
    chk("bp.p1_rsp_valid1", bus.rsp_valid1, 1);
    chk("bp.p1_rsp_out", bus.rsp_out, 32'hFF);
    tick();
    idle_inputs();

    // Asynchronous reset while in EXEC.
    set_req(0, 32'hAA, 32'h55, 4'd6);
    tick();
    chk("mid.exec_busy", bus.busy, 1);
    rst = 1;
    #1;
    chk("mid.busy", bus.busy, 0);
    chk("mid.alu_a", bus.alu_a, 0);
    chk("mid.alu_op", {28'd0, bus.alu_op}, 0);
    chk("mid.rsp_out", bus.rsp_out, 0);
    chk("mid.rsp_sign", bus.rsp_sign, 0);
    chk("mid.ready0", bus.req_ready0, 0);
    tick();
    rst = 0;
    set_req(1, 32'd1, 32'd2, 4'd0);
    #1;
    chk("mid.post_ready0", bus.req_ready0, 1);
    chk("mid.post_ready1", bus.req_ready1, 0);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port round-robin arbiter and sequencer that shares the single 32-bit ALU between two requesters (port 0: EX-stage integer path, port 1: branch-compare/auxiliary unit). It accepts one operation at a time via valid/ready handshakes and drives registered operands and opcode into the ALU instance sitting beside it. It captures the ALU result and flags, then returns them to the requester that won the grant, holding them until that requester accepts.

## Interface
- Parameters:
- `W`, 32: operand/result width; must match the ALU.
- `OPW`, 4: opcode width; must match the ALU.
- Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid0`, `req_valid1`  in  1  request valid per port.
- `req_ready0`, `req_ready1`  out  1  request accepted this cycle when paired with valid.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  W  operands per port.
- `req_op0`, `req_op1`  in  OPW  ALU opcode per port (0 ADD, 1 ADDu, 2 SUB, 3 SUBu, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 BGTZ).
- `alu_a`, `alu_b`  out  W  registered operands to the ALU.
- `alu_op`  out  OPW  registered opcode to the ALU.
- `alu_out`  in  W  ALU result (combinational from `alu_a`/`alu_b`/`alu_op`).
- `alu_zero`, `alu_overflow`, `alu_sign`  in  1  ALU flags.
- `rsp_valid0`, `rsp_valid1`  out  1  response valid per port; at most one high.
- `rsp_ready0`, `rsp_ready1`  in  1  response accept per port.
- `rsp_out`  out  W  captured result, shared by both ports.
- `rsp_zero`, `rsp_overflow`, `rsp_sign`  out  1  captured flags.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Registers: `last_grant`, `owner`.
- IDLE: grant is computed combinationally.
  - If only one `req_valid` is high, that port is granted.
  - If both are high, the port different from `last_grant` is granted.
  - `req_ready` is high only for the granted port, and only while its valid is high. Ready depends on valid; valid must never depend on ready.
  - On handshake: latch that port's a/b/op into `alu_a`/`alu_b`/`alu_op`, set `owner` and `last_grant` to the port, and go to EXEC.
- EXEC: the ALU evaluates the registered operands. At the clock edge, `alu_out` and the flags are captured into the `rsp_*` registers, `rsp_valid[owner]` is set, and the FSM goes to RESP. `req_ready` is low for both ports.
- RESP: hold `rsp_*` and `rsp_valid[owner]` stable. When `rsp_ready[owner]` is high, clear `rsp_valid` and return to IDLE. The other port's `rsp_ready` is ignored. `req_ready` is low for both ports.
- `alu_a`/`alu_b`/`alu_op` hold their last values outside a new grant.
- Opcodes 9–15 pass through unchanged. The response carries whatever the ALU returns (result 0, zero=1, overflow=0, sign=1); no error is flagged.
- Flags are forwarded bit-exact. Overflow and sign semantics are owned by the ALU, not reinterpreted here.
- Reset (asynchronous, any state, including mid-EXEC or mid-RESP):
  - State returns to IDLE; any in-flight operation is discarded.
  - `req_ready*`=0 (combinational, 0 while `rst` is high), `rsp_valid*`=0, `rsp_out`=0, `rsp_zero`=0, `rsp_overflow`=0, `rsp_sign`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `busy`=0.
  - `last_grant`=1, so port 0 wins the first contended arbitration.

## Timing
- Accept at edge T (valid&ready). `alu_*` are valid from T to T+1. Results are captured at edge T+1, and `rsp_valid` is high from T+1.
- Minimum request-to-response latency: 1 cycle after acceptance.
- Response handshake at edge R puts the FSM in IDLE from R. The earliest next acceptance is edge R+1.
- Peak throughput: one operation per 3 cycles when `rsp_ready` is held high.
- A requester that deasserts valid while in IDLE before ready simply loses that cycle's grant. `last_grant` is updated only on an actual handshake.
- Simultaneous `req_valid` and the FSM in RESP: no acceptance; both requests wait.
- The combinational path `alu_a` -> ALU -> capture register must close within one `clk` period.

## Test plan
- Single op: port 0 requests op 0 with a=5, b=7 -> `req_ready0`=1 the same cycle; one cycle later `rsp_valid0`=1, `rsp_out`=12, zero=0, overflow=0, sign=1; `rsp_valid1` stays 0.
- Overflow pass-through: port 1 requests op 0 with a=0x7FFFFFFF, b=1 -> `rsp_out`=0x80000000, overflow=1, sign=0. Then op 1 with a=0xFFFFFFFF, b=1 -> `rsp_out`=0, zero=1, overflow=1, sign=1.
- Contention and fairness: both ports hold valid continuously after reset (port 0 op 2 with a=9, b=9; port 1 op 5 with a=0xF0, b=0x0F) -> grants alternate 0,1,0,1. Port 0 responses are `rsp_out`=0 with zero=1; port 1 responses are 0xFF.
- Backpressure: `rsp_ready0`=0 for 5 cycles after `rsp_valid0` rises -> `rsp_*` stable and `busy`=1 throughout; port 1's pending request is not accepted until the cycle after `rsp_ready0`=1.
- Reset mid-operation: assert `rst` during EXEC -> all outputs take their reset values immediately without a clock edge; after release, a contended request is granted to port 0.
- Illegal opcode: op 0xC with a=3, b=4 -> `rsp_valid` is asserted normally with `rsp_out`=0, zero=1, overflow=0, sign=1.
